execute_muldiv_stage: RTL and testbench

- Execute-stage back end: takes the ALU result and forwarded operands for the instruction in EX, runs RV32M multiply/divide ops on an iterative 32-step datapath, and registers everything into the EX/MEM pipeline register.
- Its registered outputs drive the memory/writeback stage directly (the *M signals).
- Raises busy to freeze IF/ID/EX while a multi-cycle op is in flight.
- Inserts bubbles into MEM meanwhile.

---
 rtl/execute_muldiv_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_execute_muldiv_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_stage.sv
// -----------------------------------------------------------------------------
// execute_muldiv_stage
//
// Execute-stage back end. Registers the EX instruction into the EX/MEM
// pipeline register and runs RV32M multiply/divide ops on an iterative
// datapath that retires one bit per cycle (DATA_WIDTH iterations per op).
// While an M op is in flight, busy freezes IF/ID/EX and bubbles are written
// into MEM. Divide-by-zero and signed overflow are resolved in the accept
// cycle and skip the iterative phase.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        synchronous, active-low; clears all state
//   stall        downstream stall; EX/MEM register holds when 1
//   *E inputs    control and data of the instruction currently in EX
//   MulDivE      EX instruction is an RV32M op, MulDivOpE is its funct3
//   SrcAE/SrcBE  forwarded rs1/rs2 values
//   busy         stall request to IF/ID/EX
//   *M outputs   EX/MEM pipeline register contents
// -----------------------------------------------------------------------------
module execute_muldiv_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultsSrcE,
  input  logic                  MemWriteE,
  input  logic [2:0]            MemoryOpE,
  input  logic                  MulDivE,
  input  logic [2:0]            MulDivOpE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  logic [DATA_WIDTH-1:0] WriteDataE,
  input  logic [4:0]            RdE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic                  busy,
  output logic                  RegWriteM,
  output logic [1:0]            ResultsSrcM,
  output logic                  MemWriteM,
  output logic [2:0]            MemoryOpM,
  output logic [DATA_WIDTH-1:0] ALUResultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [4:0]            RdM,
  output logic [DATA_WIDTH-1:0] PCPlus4M
);

  localparam int COUNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [COUNT_W-1:0]    LAST_ITER = COUNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO      = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [COUNT_W-1:0]    count;
  logic [2:0]            op;        // latched funct3
  logic                  neg_res;   // negate product / quotient
  logic                  neg_rem;   // negate remainder (dividend sign)
  logic                  special;   // lo already holds the final answer
  logic [DATA_WIDTH-1:0] hi;        // product high / partial remainder
  logic [DATA_WIDTH-1:0] lo;        // product low+multiplier / quotient+dividend
  logic [DATA_WIDTH-1:0] opnd;      // multiplicand or divisor magnitude

  // ---------------------------------------------------------------------------
  // Accept-cycle decode
  // ---------------------------------------------------------------------------
  logic                  accept;
  logic                  sign_a, sign_b;
  logic                  neg_a, neg_b;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic                  div_zero, div_ovf;
  logic [DATA_WIDTH-1:0] special_val;

  assign accept = (state == IDLE) && MulDivE && !stall;

  // Which operands are interpreted as two's complement for this funct3.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sign_a = 1'b1;
    sign_b = 1'b1;
    case (MulDivOpE)
      3'b010:                 sign_b = 1'b0;   // MULHSU
      3'b011, 3'b101, 3'b111: begin            // MULHU, DIVU, REMU
        sign_a = 1'b0;
        sign_b = 1'b0;
      end
      default: ;
    endcase
  end

  assign neg_a = sign_a & SrcAE[DATA_WIDTH-1];
  assign neg_b = sign_b & SrcBE[DATA_WIDTH-1];
  assign mag_a = neg_a ? -SrcAE : SrcAE;
  assign mag_b = neg_b ? -SrcBE : SrcBE;

  // funct3[2] selects divide; funct3[0]==0 among divides is the signed pair.
  assign div_zero = MulDivOpE[2] && (SrcBE == ZERO);
  assign div_ovf  = MulDivOpE[2] && !MulDivOpE[0] &&
                    (SrcAE == MIN_VAL) && (SrcBE == ALL_ONES);

  // funct3[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_val = div_zero ? (MulDivOpE[1] ? SrcAE : ALL_ONES)
                                : (MulDivOpE[1] ? ZERO  : MIN_VAL);

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply / restoring divide
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0] add_sum;
  logic [DATA_WIDTH:0] sub_trial;

  assign add_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : ZERO)};
  // Shifted partial remainder minus divisor; bit DATA_WIDTH set means borrow.
  assign sub_trial = {hi, lo[DATA_WIDTH-1]} - {1'b0, opnd};

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of statement order within the block.
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      special <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= MulDivOpE;
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a;
            count   <= '0;
            hi      <= '0;
            if (div_zero || div_ovf) begin
              special <= 1'b1;
              lo      <= special_val;
              state   <= DONE;
            end else begin
              special <= 1'b0;
              state   <= RUN;
              if (MulDivOpE[2]) begin
                lo   <= mag_a;   // dividend shifts out as quotient shifts in
                opnd <= mag_b;
              end else begin
                lo   <= mag_b;   // multiplier shifts out as product shifts in
                opnd <= mag_a;
              end
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (op[2]) begin
            if (!sub_trial[DATA_WIDTH]) begin
              hi <= sub_trial[DATA_WIDTH-1:0];
              lo <= {lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
              hi <= {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};
              lo <= {lo[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {add_sum, lo[DATA_WIDTH-1:1]};
          end
          if (count == LAST_ITER) state <= DONE;
        end
        DONE: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] product_fix;
  logic [DATA_WIDTH-1:0]   quot_fix, rem_fix, result;

  assign product_fix = neg_res ? -{hi, lo} : {hi, lo};
  assign quot_fix    = neg_res ? -lo : lo;
  assign rem_fix     = neg_rem ? -hi : hi;

  always_comb begin
    result = ZERO;
    if (special)              result = lo;
    else if (op[2])           result = op[1] ? rem_fix : quot_fix;
    else if (op == 3'b000)    result = product_fix[DATA_WIDTH-1:0];
    else                      result = product_fix[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  // busy is combinational so the accept cycle itself already freezes IF/ID/EX.
  assign busy = accept || (state == RUN);

  // ---------------------------------------------------------------------------
  // EX/MEM pipeline register
  // ---------------------------------------------------------------------------
  logic load_bubble;
  assign load_bubble = (state == RUN) || ((state == IDLE) && MulDivE);

  always_ff @(posedge clk) begin
    if (!reset || (!stall && load_bubble)) begin
      RegWriteM   <= 1'b0;
      ResultsSrcM <= 2'b00;
      MemWriteM   <= 1'b0;
      MemoryOpM   <= 3'b000;
      ALUResultM  <= '0;
      WriteDataM  <= '0;
      RdM         <= '0;
      PCPlus4M    <= '0;
    end else if (!stall) begin
      RegWriteM   <= RegWriteE;
      ResultsSrcM <= ResultsSrcE;
      MemWriteM   <= MemWriteE;
      MemoryOpM   <= MemoryOpE;
      ALUResultM  <= (state == DONE) ? result : ALUResultE;
      WriteDataM  <= WriteDataE;
      RdM         <= RdE;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_muldiv_stage
//
// Bench for execute_muldiv_stage. A transaction-level model predicts the
// EX/MEM register and busy every cycle from the RV32M arithmetic rules (64-bit
// integer math) and a remaining-cycle count. Directed cases cover the plain
// pass-through, multiply/divide latency, special divides, stall in the final
// cycle and reset abort; a randomized stream follows.
// -----------------------------------------------------------------------------
module tb_execute_muldiv_stage;

  localparam int W = 32;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  results_src;
    logic        mem_write;
    logic [2:0]  memory_op;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
  } m_t;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic        RegWriteE, MemWriteE, MulDivE;
  logic [1:0]  ResultsSrcE;
  logic [2:0]  MemoryOpE, MulDivOpE;
  logic [31:0] ALUResultE, SrcAE, SrcBE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        busy, RegWriteM, MemWriteM;
  logic [1:0]  ResultsSrcM;
  logic [2:0]  MemoryOpM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int checks   = 0;
  int failures = 0;

  execute_muldiv_stage #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .RegWriteE(RegWriteE), .ResultsSrcE(ResultsSrcE), .MemWriteE(MemWriteE),
    .MemoryOpE(MemoryOpE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .ALUResultE(ALUResultE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
    .busy(busy), .RegWriteM(RegWriteM), .ResultsSrcM(ResultsSrcM),
    .MemWriteM(MemWriteM), .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb;              return p[31:0];  end
      3'd1: begin p = sa * sb;              return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);    return p[63:32]; end
      3'd3: begin p = ua * ub;              return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (op >= 3'd4 && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction model: one M op in flight, counted down in cycles
  // ---------------------------------------------------------------------------
  m_t          exp_m       = '0;
  bit          m_inflight  = 0;
  int          m_remaining = 0;
  logic [31:0] m_result    = '0;
  int          consumed    = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_inflight  = 0;
      m_remaining = 0;
      exp_m       = '0;
    end else if (m_inflight) begin
      if (m_remaining > 0) begin
        m_remaining--;
        if (!stall) exp_m = '0;
      end else if (!stall) begin
        exp_m = {RegWriteE, ResultsSrcE, MemWriteE, MemoryOpE, m_result,
                 WriteDataE, RdE, PCPlus4E};
        m_inflight = 0;
        consumed++;
      end
    end else if (MulDivE) begin
      if (!stall) begin
        m_inflight  = 1;
        m_result    = ref_result(MulDivOpE, SrcAE, SrcBE);
        m_remaining = is_special(MulDivOpE, SrcAE, SrcBE) ? 0 : W;
        exp_m       = '0;
      end
    end else if (!stall) begin
      exp_m = {RegWriteE, ResultsSrcE, MemWriteE, MemoryOpE, ALUResultE,
               WriteDataE, RdE, PCPlus4E};
      consumed++;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, mid-cycle
  // ---------------------------------------------------------------------------
  bit chk_en   = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    m_t  act;
    bit  exp_busy;
    if (chk_en) begin
      act = {RegWriteM, ResultsSrcM, MemWriteM, MemoryOpM, ALUResultM,
             WriteDataM, RdM, PCPlus4M};
      exp_busy = m_inflight ? (m_remaining > 0) : (MulDivE && !stall);
      check("exmem", 128'(act), 128'(exp_m));
      check("busy", 128'(busy), 128'(exp_busy));
      if (busy === 1'b1) busy_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic md, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] alu,
                           input logic [4:0] rd, input logic rw);
    MulDivE     = md;
    MulDivOpE   = op;
    SrcAE       = a;
    SrcBE       = b;
    ALUResultE  = alu;
    RdE         = rd;
    RegWriteE   = rw;
    ResultsSrcE = 2'b00;
    MemWriteE   = 1'b0;
    MemoryOpE   = 3'b010;
    WriteDataE  = 32'h1234_5678;
    PCPlus4E    = 32'h0000_0104;
  endtask

  // Holds the instruction until it leaves EX; returns edges taken.
  task automatic run_op(input int stall_pct, output int cycles);
    int start;
    start  = consumed;
    cycles = 0;
    stall  = ($urandom_range(99) < stall_pct);
    while (consumed == start && cycles < 300) begin
      step();
      cycles++;
      stall = ($urandom_range(99) < stall_pct);
    end
    if (consumed == start) check("op_timeout", 128'(cycles), 128'(0));
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(15));
      4:       return -32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cyc, b0, guard;

    // Model pinned to hand-computed values.
    check("ref_mul",    128'(ref_result(3'd0, 32'hFFFF_FFFD, 32'd7)), 128'(32'hFFFF_FFEB));
    check("ref_mulhu",  128'(ref_result(3'd3, 32'hFFFF_FFFD, 32'd7)), 128'(32'h0000_0006));
    check("ref_div",    128'(ref_result(3'd4, 32'hFFFF_FFF9, 32'd2)), 128'(32'hFFFF_FFFD));
    check("ref_rem",    128'(ref_result(3'd6, 32'hFFFF_FFF9, 32'd2)), 128'(32'hFFFF_FFFF));
    check("ref_divu0",  128'(ref_result(3'd5, 32'd7, 32'd0)),         128'(32'hFFFF_FFFF));
    check("ref_remu0",  128'(ref_result(3'd7, 32'd7, 32'd0)),         128'(32'd7));
    check("ref_divovf", 128'(ref_result(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)), 128'(32'h8000_0000));
    check("ref_removf", 128'(ref_result(3'd6, 32'h8000_0000, 32'hFFFF_FFFF)), 128'(32'h0));

    // Reset
    reset = 1'b0;
    stall = 1'b0;
    set_instr(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    chk_en = 1;
    step();
    check("reset_alu",  128'(ALUResultM), 128'(0));
    check("reset_rw",   128'(RegWriteM),  128'(0));
    check("reset_busy", 128'(busy),       128'(0));
    reset = 1'b1;

    // Non-M pass-through
    set_instr(1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0010, 5'd5, 1'b1);
    b0 = busy_cnt;
    run_op(0, cyc);
    check("add_lat",  128'(cyc),        128'(1));
    check("add_alu",  128'(ALUResultM), 128'(32'h10));
    check("add_rd",   128'(RdM),        128'(5));
    check("add_rw",   128'(RegWriteM),  128'(1));
    check("add_busy", 128'(busy_cnt - b0), 128'(0));

    // MUL -3*7: 33 busy cycles, result on the 34th edge
    set_instr(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hDEAD_BEEF, 5'd6, 1'b1);
    b0 = busy_cnt;
    run_op(0, cyc);
    check("mul_lat",  128'(cyc),            128'(34));
    check("mul_busy", 128'(busy_cnt - b0),  128'(33));
    check("mul_res",  128'(ALUResultM),     128'(32'hFFFF_FFEB));

    set_instr(1'b1, 3'd3, 32'hFFFF_FFFD, 32'd7, 32'h0, 5'd7, 1'b1);
    run_op(0, cyc);
    check("mulhu_res", 128'(ALUResultM), 128'(32'h6));

    set_instr(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd8, 1'b1);
    run_op(0, cyc);
    check("div_res", 128'(ALUResultM), 128'(32'hFFFF_FFFD));

    set_instr(1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd9, 1'b1);
    run_op(0, cyc);
    check("rem_res", 128'(ALUResultM), 128'(32'hFFFF_FFFF));

    // Special divides finish in 2 cycles
    set_instr(1'b1, 3'd5, 32'd7, 32'd0, 32'h0, 5'd10, 1'b1);
    run_op(0, cyc);
    check("divu0_lat", 128'(cyc),        128'(2));
    check("divu0_res", 128'(ALUResultM), 128'(32'hFFFF_FFFF));

    set_instr(1'b1, 3'd7, 32'd7, 32'd0, 32'h0, 5'd11, 1'b1);
    run_op(0, cyc);
    check("remu0_res", 128'(ALUResultM), 128'(32'd7));

    set_instr(1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b1);
    run_op(0, cyc);
    check("divovf_lat", 128'(cyc),        128'(2));
    check("divovf_res", 128'(ALUResultM), 128'(32'h8000_0000));

    set_instr(1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd13, 1'b1);
    run_op(0, cyc);
    check("removf_res", 128'(ALUResultM), 128'(32'h0));

    // Stall held across the final cycle
    set_instr(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 32'h0, 5'd14, 1'b1);
    stall = 1'b0;
    guard = 0;
    while (!(m_inflight && m_remaining == 0) && guard < 100) begin
      step();
      guard++;
    end
    check("done_reached", 128'(m_inflight && m_remaining == 0), 128'(1));
    stall = 1'b1;
    repeat (3) step();
    check("done_hold_alu", 128'(ALUResultM), 128'(0));
    check("done_hold_rd",  128'(RdM),        128'(0));
    stall = 1'b0;
    step();
    check("done_release_alu", 128'(ALUResultM), 128'(32'hFFFF_FFEB));
    check("done_release_rd",  128'(RdM),        128'(14));

    // Reset in the middle of RUN
    set_instr(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 32'h0, 5'd15, 1'b1);
    repeat (11) step();
    reset = 1'b0;
    set_instr(1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_0010, 5'd5, 1'b1);
    step();
    check("abort_alu",  128'(ALUResultM), 128'(0));
    check("abort_rw",   128'(RegWriteM),  128'(0));
    check("abort_busy", 128'(busy),       128'(0));
    reset = 1'b1;
    run_op(0, cyc);
    check("post_abort_alu", 128'(ALUResultM), 128'(32'h10));
    check("post_abort_rd",  128'(RdM),        128'(5));

    // Randomized stream with random downstream stalls
    for (int i = 0; i < 300; i++) begin
      set_instr(($urandom_range(99) < 40), 3'($urandom_range(7)), rand_opnd(), rand_opnd(),
                $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)));
      ResultsSrcE = 2'($urandom_range(2));
      MemWriteE   = 1'($urandom_range(1));
      MemoryOpE   = 3'($urandom_range(7));
      WriteDataE  = $urandom;
      PCPlus4E    = $urandom;
      run_op(25, cyc);
    end

    stall = 1'b0;
    step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
